// File: rtl/clock_enable_gen.sv
// -----------------------------------------------------------------------------
// clock_enable_gen
//
// Multi-channel programmable clock-enable generator. Each channel divides the
// single input clock by its own divisor and emits a one-cycle enable pulse
// (o_tick) once per period, plus a square wave (o_level) that toggles on every
// tick. Channels can be halted individually with i_run and, when the
// single-step feature is compiled in, advanced one tick at a time with i_step.
//
// Optional feature macro: CLOCK_ENABLE_GEN_STEP_EN
//   defined   -> a rising edge on i_step makes every halted channel tick once.
//   undefined -> i_step is present but ignored; halted channels never tick.
//
// Parameters
//   INPUT_CLOCK  input clock frequency in Hz (only used to derive DEFAULT_DIV)
//   CHANNELS     number of independent tick channels (1..8)
//   WIDTH        width of each divisor and counter
//   DEFAULT_DIV  divisor loaded at reset (1 tick per second by default)
//
// Ports
//   i_clk        clock, all logic on posedge
//   i_reset      asynchronous active-high reset
//   i_wr_en      divisor write strobe
//   i_wr_chan    channel index for the write (out-of-range indices ignored)
//   i_wr_div     new divisor value
//   i_run        per-channel run enable
//   i_step       single-step request (level, edge-detected internally)
//   o_tick       one-cycle clock-enable pulse per channel
//   o_level      square wave per channel, toggles on each tick
// -----------------------------------------------------------------------------
module clock_enable_gen #(
    parameter int INPUT_CLOCK = 16_000_000,
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = INPUT_CLOCK
) (
    input  logic                                          i_clk,
    input  logic                                          i_reset,
    input  logic                                          i_wr_en,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] i_wr_chan,
    input  logic [WIDTH-1:0]                              i_wr_div,
    input  logic [CHANNELS-1:0]                           i_run,
    input  logic                                          i_step,
    output logic [CHANNELS-1:0]                           o_tick,
    output logic [CHANNELS-1:0]                           o_level
);

    logic [WIDTH-1:0]    cnt_q [CHANNELS];
    logic [WIDTH-1:0]    cnt_d [CHANNELS];
    logic [WIDTH-1:0]    div_q [CHANNELS];
    logic [WIDTH-1:0]    div_d [CHANNELS];
    logic [CHANNELS-1:0] tick_q;
    logic [CHANNELS-1:0] tick_d;
    logic [CHANNELS-1:0] level_q;
    logic [CHANNELS-1:0] level_d;
    logic                step_q;
    logic                step_d;
    logic                step_rise;

    // Step history: the previous sample of i_step, so a held level only
    // produces one step.
    assign step_d = i_step;

`ifdef CLOCK_ENABLE_GEN_STEP_EN
    assign step_rise = i_step & ~step_q;
`else
    // Feature compiled out: the step input is masked off entirely and the
    // history register is never consulted.
    assign step_rise = i_step & step_q & 1'b0;
`endif

    always_comb begin
        logic [WIDTH-1:0] eff_div;
        logic             wr_hit;
        logic             terminal;
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_d[c]   = cnt_q[c];
            div_d[c]   = div_q[c];
            tick_d[c]  = 1'b0;
            // Divisors 0 and 1 both mean "tick every cycle".
            eff_div    = (div_q[c] <= WIDTH'(1)) ? WIDTH'(1) : div_q[c];
            // >= rather than == so the counter can never run past the
            // terminal count, whatever state it is found in.
            terminal   = (cnt_q[c] >= (eff_div - WIDTH'(1)));
            // An index >= CHANNELS matches no channel, so such writes are
            // dropped without a separate range check.
            wr_hit     = i_wr_en && (32'(i_wr_chan) == 32'(c));

            if (wr_hit) begin
                // Write wins over a coincident terminal count or step.
                div_d[c] = i_wr_div;
                cnt_d[c] = '0;
            end else if (i_run[c]) begin
                if (terminal) begin
                    cnt_d[c]  = '0;
                    tick_d[c] = 1'b1;
                end else begin
                    cnt_d[c]  = cnt_q[c] + WIDTH'(1);
                end
            end else begin
                // Halted: count holds; only a step can tick.
                tick_d[c] = step_rise;
            end
            level_d[c] = level_q[c] ^ tick_d[c];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= '0;
                div_q[c] <= WIDTH'(DEFAULT_DIV);
            end
            tick_q  <= '0;
            level_q <= '0;
            step_q  <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= cnt_d[c];
                div_q[c] <= div_d[c];
            end
            tick_q  <= tick_d;
            level_q <= level_d;
            step_q  <= step_d;
        end
    end

    assign o_tick  = tick_q;
    assign o_level = level_q;

endmodule

// File: tb/tb_clock_enable_gen.sv
// -----------------------------------------------------------------------------
// tb_clock_enable_gen
//
// Self-checking bench for clock_enable_gen (2 channels, DEFAULT_DIV = 10).
// The driver applies one set of inputs per cycle and pushes the expected
// {o_level, o_tick} for the following edge into exp_q; a monitor pops and
// compares on every falling edge. The reference model counts running cycles
// since the last write/reset and predicts a tick whenever that count is a
// multiple of the effective divisor.
// -----------------------------------------------------------------------------
module tb_clock_enable_gen;

    localparam int CH  = 2;
    localparam int W   = 32;
    localparam int DEF = 10;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_wr_en;
    logic          i_wr_chan;
    logic [W-1:0]  i_wr_div;
    logic [CH-1:0] i_run;
    logic          i_step;
    logic [CH-1:0] o_tick;
    logic [CH-1:0] o_level;

    clock_enable_gen #(
        .INPUT_CLOCK (16_000_000),
        .CHANNELS    (CH),
        .WIDTH       (W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_wr_en   (i_wr_en),
        .i_wr_chan (i_wr_chan),
        .i_wr_div  (i_wr_div),
        .i_run     (i_run),
        .i_step    (i_step),
        .o_tick    (o_tick),
        .o_level   (o_level)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard state
    logic [2*CH-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model state
    longint unsigned elapsed [CH];
    logic [W-1:0]    div_m   [CH];
    logic [CH-1:0]   level_m;
    logic            prev_step_m;
    int              tick_total [CH];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            elapsed[c] = 0;
            div_m[c]   = W'(DEF);
        end
        level_m     = '0;
        prev_step_m = 1'b0;
    endtask

    // Predict outputs after the coming edge from the inputs now applied.
    task automatic model_step(output logic [CH-1:0] tick_e);
        logic            rise;
        longint unsigned eff;
`ifdef CLOCK_ENABLE_GEN_STEP_EN
        rise = i_step && !prev_step_m;
`else
        rise = 1'b0;
`endif
        for (int c = 0; c < CH; c++) begin
            eff = (div_m[c] < 2) ? 1 : longint'(div_m[c]);
            if (i_wr_en && int'(i_wr_chan) == c) begin
                div_m[c]   = i_wr_div;
                elapsed[c] = 0;
                tick_e[c]  = 1'b0;
            end else if (i_run[c]) begin
                elapsed[c] = elapsed[c] + 1;
                tick_e[c]  = (elapsed[c] % eff) == 0;
            end else begin
                tick_e[c]  = rise;
            end
            if (tick_e[c]) level_m[c] = ~level_m[c];
        end
        prev_step_m = i_step;
    endtask

    // Driver: one cycle of stimulus.
    task automatic drive(input logic rst, input logic wr_en, input logic wr_chan,
                         input logic [W-1:0] wr_div, input logic [CH-1:0] run,
                         input logic step);
        logic [CH-1:0] tick_e;
        @(negedge clk);
        #1;
        i_reset   = rst;
        i_wr_en   = wr_en;
        i_wr_chan = wr_chan;
        i_wr_div  = wr_div;
        i_run     = run;
        i_step    = step;
        if (rst) begin
            #1;
            checks++;
            if (o_tick !== '0 || o_level !== '0) begin
                errors++;
                $display("FAIL async_reset_clear cycle %0d: tick=%b level=%b required tick=00 level=00",
                         cycle, o_tick, o_level);
            end
            model_reset();
            exp_q.push_back('0);
        end else begin
            model_step(tick_e);
            exp_q.push_back({level_m, tick_e});
        end
    endtask

    task automatic idle(input int n, input logic [CH-1:0] run, input logic step);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, run, step);
    endtask

    task automatic write_div(input logic chan, input logic [W-1:0] d, input logic [CH-1:0] run);
        drive(1'b0, 1'b1, chan, d, run, 1'b0);
    endtask

    // Monitor: compare DUT outputs against the oldest expectation.
    always @(negedge clk) begin
        logic [2*CH-1:0] exp_v;
        cycle++;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if ({o_level, o_tick} !== exp_v) begin
                errors++;
                $display("FAIL outputs cycle %0d: tick=%b level=%b required tick=%b level=%b",
                         cycle, o_tick, o_level, exp_v[CH-1:0], exp_v[2*CH-1:CH]);
            end
            for (int c = 0; c < CH; c++) if (o_tick[c]) tick_total[c]++;
        end
    end

    initial begin
        int t0 [CH];
        i_reset   = 1'b1;
        i_wr_en   = 1'b0;
        i_wr_chan = 1'b0;
        i_wr_div  = '0;
        i_run     = '0;
        i_step    = 1'b0;
        for (int c = 0; c < CH; c++) tick_total[c] = 0;
        model_reset();

        // Reset state
        drive(1'b1, 1'b0, 1'b0, '0, 2'b00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, '0, 2'b00, 1'b0);

        // div[0]=4, only channel 0 running
        write_div(1'b0, 32'd4, 2'b01);
        idle(24, 2'b01, 1'b0);

        // Channel 1: divisor 0 then 1, both tick every cycle
        write_div(1'b1, 32'd0, 2'b10);
        idle(6, 2'b10, 1'b0);
        write_div(1'b1, 32'd1, 2'b10);
        idle(6, 2'b10, 1'b0);

        // Write div=5 exactly on channel 0's terminal count (cnt==3 of div 4)
        write_div(1'b0, 32'd4, 2'b01);
        idle(3, 2'b01, 1'b0);
        write_div(1'b0, 32'd5, 2'b01);
        idle(12, 2'b01, 1'b0);

        // Pause/resume keeps the partial count
        idle(3, 2'b00, 1'b0);
        idle(8, 2'b01, 1'b0);

        // One-cycle reset mid-period, then DEFAULT_DIV period on both channels
        idle(2, 2'b11, 1'b0);
        drive(1'b1, 1'b0, 1'b0, '0, 2'b11, 1'b0);
        idle(22, 2'b11, 1'b0);

        // Step held high for 5 cycles with everything halted: one tick each
        idle(2, 2'b00, 1'b0);
        @(negedge clk);
        #2;
        for (int c = 0; c < CH; c++) t0[c] = tick_total[c];
        idle(5, 2'b00, 1'b1);
        idle(3, 2'b00, 1'b0);
        @(negedge clk);
        #2;
        for (int c = 0; c < CH; c++) begin
            checks++;
`ifdef CLOCK_ENABLE_GEN_STEP_EN
            if (tick_total[c] - t0[c] != 1) begin
`else
            if (tick_total[c] - t0[c] != 0) begin
`endif
                errors++;
                $display("FAIL step_tick_count ch%0d: got %0d ticks", c, tick_total[c] - t0[c]);
            end
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic          r_rst;
            logic          r_wr;
            logic [CH-1:0] r_run;
            r_rst = ($urandom_range(0, 99) == 0);
            r_wr  = ($urandom_range(0, 9) == 0);
            r_run = ($urandom_range(0, 3) == 0) ? CH'($urandom_range(0, 3)) : 2'b11;
            drive(r_rst, r_wr, 1'($urandom_range(0, 1)), W'($urandom_range(0, 7)),
                  r_run, 1'($urandom_range(0, 1)));
        end
        idle(2, 2'b00, 1'b0);

        // Drain the scoreboard
        @(negedge clk);
        @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_enable_gen.md
CLOCK_ENABLE_GEN -- requirements
Module: clock_enable_gen

Interface
- REQ-001 The module SHALL have parameter INPUT_CLOCK, default 16_000_000: input clock frequency in Hz, documentation only, used to derive DEFAULT_DIV.
- REQ-002 The module SHALL have parameter CHANNELS, default 2: number of independent tick channels, legal range 1..8.
- REQ-003 The module SHALL have parameter WIDTH, default 32: width of each divisor and counter.
- REQ-004 The module SHALL have parameter DEFAULT_DIV, default INPUT_CLOCK: divisor loaded at reset, giving 1 tick/s.
- REQ-005 The module SHALL have port i_clk, input, 1 bit: single clock, all logic on posedge.
- REQ-006 The module SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
- REQ-007 The module SHALL have port i_wr_en, input, 1 bit: divisor write strobe.
- REQ-008 The module SHALL have port i_wr_chan, input, max(1,$clog2(CHANNELS)) bits: channel index for the write.
- REQ-009 The module SHALL have port i_wr_div, input, WIDTH bits: new divisor value.
- REQ-010 The module SHALL have port i_run, input, CHANNELS bits: per-channel run enable.
- REQ-011 The module SHALL have port i_step, input, 1 bit: single-step request, level input.
- REQ-012 The module SHALL have port o_tick, output, CHANNELS bits: one-cycle clock-enable pulse per channel.
- REQ-013 The module SHALL have port o_level, output, CHANNELS bits: 50%-style square wave that toggles on every tick of its channel.

Function
- REQ-014 Each channel SHALL hold a WIDTH-bit divisor register div[c] and a WIDTH-bit counter cnt[c].
- REQ-015 When i_run[c]=1 and no write targets c, cnt[c] SHALL increment each cycle; when cnt[c]==eff_div-1, cnt[c] SHALL wrap to 0 and o_tick[c] SHALL be 1 on the following cycle only.
- REQ-016 The effective divisor eff_div SHALL be 1 when div[c] is 0 or 1, so the channel ticks every cycle; otherwise eff_div SHALL equal div[c].
- REQ-017 Tick period SHALL be exactly eff_div cycles in steady state, with o_tick registered (1-cycle latency from terminal count).
- REQ-018 o_level[c] SHALL toggle in the same cycle o_tick[c] is 1.
- REQ-019 A write with i_wr_en=1 SHALL load div[i_wr_chan] and clear cnt[i_wr_chan] to 0 on the same edge; the first tick SHALL follow eff_div cycles later.
- REQ-020 A write coinciding with the target channel's terminal count SHALL take priority: no tick is issued, the counter clears, and o_level does not toggle.
- REQ-021 Writes with i_wr_chan >= CHANNELS SHALL be ignored.
- REQ-022 Writes SHALL NOT disturb any non-targeted channel.
- REQ-023 When i_run[c]=0, cnt[c] SHALL hold its value, and o_tick[c] SHALL be 0 except as given in REQ-030.
- REQ-024 Deasserting i_run[c] SHALL NOT clear cnt[c]; reasserting it SHALL resume counting from the held value.
- REQ-025 Counter arithmetic SHALL be unsigned modulo 2^WIDTH, and no count value SHALL be reachable beyond eff_div-1.

Reset
- REQ-026 While i_reset=1, regardless of clock, the module SHALL set cnt=0, div=DEFAULT_DIV, o_tick=0, o_level=0, and the step history register to 0, for all channels.
- REQ-027 Reset asserted mid-period SHALL discard partial counts and any pending tick; after release, the first tick SHALL occur DEFAULT_DIV cycles after the first active edge.
- REQ-028 Release of i_reset SHALL be assumed synchronous to i_clk by the integrating top level.

Configuration
- REQ-029 The macro CLOCK_ENABLE_GEN_STEP_EN SHALL compile the single-step feature in or out.
- REQ-030 With CLOCK_ENABLE_GEN_STEP_EN defined, the module SHALL register i_step each cycle; when the current sample is 1 and the previous sample is 0, every channel with i_run[c]=0 SHALL assert o_tick[c] for exactly one cycle on the next cycle, toggle o_level[c], and leave cnt[c] unchanged; running channels SHALL ignore the step.
- REQ-031 Holding i_step high SHALL produce only one step tick.
- REQ-032 Without CLOCK_ENABLE_GEN_STEP_EN, the i_step port SHALL remain present but unused, and halted channels SHALL never tick.

Verification
- REQ-033 The bench SHALL run default parameters with div[0] written to 4 and i_run=2'b01 -> o_tick[0] pulses every 4 cycles, o_level[0] period 8 cycles, o_tick[1]=0.
- REQ-034 The bench SHALL write div=0 and then div=1 to channel 1 with i_run=2'b10 -> o_tick[1]=1 every cycle, and o_level[1] toggles every cycle.
- REQ-035 The bench SHALL write div=5 on the exact cycle cnt reaches 3 of div=4 -> no tick that period, and the next tick arrives 5 cycles after the write.
- REQ-036 The bench SHALL assert i_reset for 1 cycle mid-period with DEFAULT_DIV overridden to 10 -> all outputs 0 immediately, and the first tick arrives 10 cycles after release.
- REQ-037 With CLOCK_ENABLE_GEN_STEP_EN defined, i_run=0, and i_step held high for 5 cycles, the bench SHALL check -> exactly one o_tick pulse on each channel, 1 cycle after the rising edge; without the macro -> no ticks.
